// File: rtl/serial_pkg.sv
// Shared definitions for the odd-parity serial path: state codes, frame
// geometry and the parity function used by generator, transmitter and receiver.
package serial_pkg;

  localparam int FRAME_BITS = 7;
  localparam int DATA_BITS  = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Data plus this bit always carries an odd number of ones.
  function automatic logic odd_parity4(input logic [3:0] din);
    return ~^din;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-window timer: counts CLKS_PER_BIT cycles per frame bit and flags the
// last cycle of each window with tick.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Down-counter: "clear" restarts a full window, so it loads the reload value
  // rather than zero; it also reloads itself after every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/odd_parity_serial_tx.sv
// Frames 4-bit words as start, data LSB-first, odd parity and stop bits on a
// single registered line that idles high.
module odd_parity_serial_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       busy,
  output logic       p,
  output logic       frame_done,
  output logic [2:0] state_dbg
);

  import serial_pkg::*;

  localparam logic [1:0] LAST_IDX = 2'(DATA_BITS - 1);

  // Handshake: a word moves when din_valid && din_ready are both high at a
  // rising edge; din_valid outside IDLE is ignored and din is not re-read.
  state_t     state;
  state_t     next_state;
  logic [3:0] shift;
  logic [1:0] bit_idx;
  logic       tick;
  logic       accept;

  assign accept = din_valid && (state == ST_IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (din_valid)                     next_state = ST_START;
      ST_START:  if (tick)                          next_state = ST_DATA;
      ST_DATA:   if (tick && (bit_idx == LAST_IDX)) next_state = ST_PARITY;
      ST_PARITY: if (tick)                          next_state = ST_STOP;
      ST_STOP:   if (tick)                          next_state = ST_IDLE;
      default:                                      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    din_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_STOP) && tick;
    state_dbg  = state;
  end

  // tx is loaded with the value of the window that starts at this edge, so the
  // line changes exactly on window boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_idx <= '0;
      p       <= 1'b0;
      tx      <= 1'b1;
    end else if (accept) begin
      shift   <= din;
      bit_idx <= '0;
      p       <= odd_parity4(din);
      tx      <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_START: tx <= shift[0];
        ST_DATA: begin
          shift   <= {1'b0, shift[3:1]};
          bit_idx <= bit_idx + 2'd1;
          tx      <= (bit_idx == LAST_IDX) ? p : shift[1];
        end
        default:  tx <= 1'b1;
      endcase
    end
  end

endmodule
